// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/serial_sub_sub_bit.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow out.
module sub_bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor: D = (A - B - Bin) mod 2^N, one bit per cycle, LSB first.
// Optional signed-overflow output V is enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Bin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] D,
`ifdef SERIAL_SUB_OVF_EN
    output logic         V,
`endif
    output logic         Bout
);

    localparam int CNT_W = $clog2(N) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(N - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     a_q, a_d;
    logic [N-1:0]     b_q, b_d;
    logic             br_q, br_d;
    logic [N-1:0]     res_q, res_d;
    logic [N-1:0]     dout_q, dout_d;
    logic             bout_q, bout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             d_s, bout_s;
`ifdef SERIAL_SUB_OVF_EN
    logic             amsb_q, amsb_d;
    logic             bmsb_q, bmsb_d;
    logic             v_q, v_d;
`endif

    sub_bit u_sub_bit (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (br_q),
        .d    (d_s),
        .bout (bout_s)
    );

    // Next-state, datapath and output-register logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        br_d    = br_q;
        res_d   = res_q;
        dout_d  = dout_q;
        bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
        amsb_d  = amsb_q;
        bmsb_d  = bmsb_q;
        v_d     = v_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    a_d     = A;
                    b_d     = B;
                    br_d    = Bin;
                    res_d   = '0;
`ifdef SERIAL_SUB_OVF_EN
                    amsb_d  = A[N-1];
                    bmsb_d  = B[N-1];
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                a_d   = {1'b0, a_q[N-1:1]};
                b_d   = {1'b0, b_q[N-1:1]};
                br_d  = bout_s;
                res_d = {d_s, res_q[N-1:1]};
                cnt_d = cnt_q + CNT_W'(1);
                // The last bit's d lands in the MSB, so the full result is res_d.
                if (cnt_q == LAST_BIT) begin
                    state_d = DONE;
                    dout_d  = res_d;
                    bout_d  = bout_s;
`ifdef SERIAL_SUB_OVF_EN
                    v_d     = (amsb_q ^ bmsb_q) & (amsb_q ^ d_s);
`endif
                end else begin
                    state_d = SHIFT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            br_q    <= 1'b0;
            res_q   <= '0;
            dout_q  <= '0;
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            amsb_q  <= 1'b0;
            bmsb_q  <= 1'b0;
            v_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            br_q    <= br_d;
            res_q   <= res_d;
            dout_q  <= dout_d;
            bout_q  <= bout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SERIAL_SUB_OVF_EN
            amsb_q  <= amsb_d;
            bmsb_q  <= bmsb_d;
            v_q     <= v_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign D    = dout_q;
    assign Bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign V    = v_q;
`endif

endmodule

// File: doc/serial_sub.md
SERIAL_SUB -- requirements
Module: serial_sub

Interface
REQ-001 Parameter N SHALL default to 4 and set operand/result width (N >= 2).
REQ-002 The block SHALL use one clock; reset is synchronous and active-low, with ports clk and rst_n.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 start  input  1  request; sampled only when accepted (IDLE or DONE).
REQ-006 A  input  N  minuend, captured on the accepted start.
REQ-007 B  input  N  subtrahend, captured on the accepted start.
REQ-008 Bin  input  1  borrow-in, captured on the accepted start.
REQ-009 busy  output  1  high while in SHIFT.
REQ-010 done  output  1  one-cycle pulse, high in DONE.
REQ-011 D  output  N  difference (A - B - Bin) mod 2^N, registered.
REQ-012 Bout  output  1  borrow-out, 1 when A < B + Bin unsigned.

Function
REQ-013 The FSM SHALL have states IDLE, SHIFT and DONE.
REQ-014 IDLE with start=1: capture A, B, Bin into internal shift registers, clear bit counter, go to SHIFT; start=0: stay.
REQ-015 SHIFT: each cycle process one bit LSB-first: d = a^b^br; br_next = (~a&b) | (~(a^b)&br).
REQ-016 SHIFT: shift d into the result register from the MSB end, increment counter, after the N-th bit go to DONE.
REQ-017 On entry to DONE, D SHALL load the full result and Bout the final borrow, in the same edge.
REQ-018 DONE: with start=1, behave as IDLE with start (back-to-back accept); else go to IDLE.
REQ-019 Latency SHALL be exactly N+1 edges from the accepting edge to done high; done is high exactly one cycle.
REQ-020 start, A, B and Bin SHALL be ignored while in SHIFT; captured operands are unaffected by input changes.
REQ-021 D and Bout SHALL hold their last values until the next transition into DONE, not during SHIFT.
REQ-022 busy SHALL be 1 only in SHIFT; busy and done SHALL never be high together.

Reset
REQ-023 When rst_n=0 at a rising edge, the block SHALL go to IDLE and clear D, Bout, busy, done, the counter and the internal registers to 0.
REQ-024 Reset mid-SHIFT SHALL abort the operation with no done pulse, and D/Bout SHALL read 0.
REQ-025 On the first edge with rst_n=1, start SHALL be accepted normally.

Configuration
REQ-026 With SERIAL_SUB_OVF_EN defined, output V (1 bit) SHALL exist, registered with D: V = (A[N-1]^B[N-1]) & (A[N-1]^D[N-1]) on captured A/B, reset 0.
REQ-027 Without SERIAL_SUB_OVF_EN, port V and its logic SHALL be absent, with all other behaviour identical.

Structure
REQ-028 Package serial_sub_pkg SHALL hold the state encoding constants (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2).
REQ-029 A 1-bit combinational cell sub_bit (a, b, bin -> d, bout) SHALL be instantiated once for the per-cycle bit slice.
REQ-030 The counter width SHALL be $clog2(N)+1.

Verification (N=4)
REQ-031 A=7, B=3, Bin=0, start one cycle -> busy for 4 cycles, then done with D=4, Bout=0 (V=0).
REQ-032 A=3, B=7, Bin=0 -> D=12, Bout=1; A=0, B=0, Bin=1 -> D=15, Bout=1.
REQ-033 start re-asserted with A=1, B=1 during SHIFT of the 7-3 operation -> ignored; result D=4, done pulses once.
REQ-034 start held high in DONE with new A=9, B=2 -> accepted back-to-back, next done gives D=7, Bout=0, previous D=4 held meanwhile.
REQ-035 rst_n=0 in the 2nd SHIFT cycle -> IDLE, D=0, Bout=0, no done; next start with A=5, B=5 -> D=0, Bout=0.
REQ-036 SERIAL_SUB_OVF_EN defined, A=8, B=1 -> D=7, Bout=0, V=1; A=2, B=1 -> V=0.
